// File: rtl/fir_wb_sequencer.sv
// Wishbone master that sequences the FIR accelerator: programs length, starts it,
// streams samples src -> FIR -> dst one classic transfer at a time, then polls ap_done.
module fir_wb_sequencer #(
    parameter logic [31:0] FIR_BASE = 32'h3000_0300,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [31:0] len,
    input  logic [31:0] src_base,
    input  logic [31:0] dst_base,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i
);

    localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    typedef enum logic [3:0] {
        IDLE, CFG_LEN, CFG_START, RD_SRC, WR_X, RD_Y, WR_DST, POLL, FIN
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   len_q, len_d, src_q, src_d, dst_q, dst_d;
    logic [31:0]   i_q, i_d, x_q, x_d, y_q, y_d;
    logic [31:0]   adr_q, adr_d, dat_q, dat_d;
    logic          cyc_q, cyc_d, we_q, we_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          req_we;
    logic [31:0]   req_adr, req_dat;
    logic          timeout;

    assign timeout = cyc_q && !m_ack_i && (tmo_q == TW'(TIMEOUT - 1));

    // Transfer that the current state issues once the bus is idle.
    always_comb begin
        req_we  = 1'b0;
        req_adr = FIR_BASE;
        req_dat = dat_q;
        case (state_q)
            CFG_LEN:   begin req_we = 1'b1; req_adr = FIR_BASE + 32'h10; req_dat = len_q; end
            CFG_START: begin req_we = 1'b1; req_dat = 32'h1; end
            RD_SRC:    req_adr = src_q + {i_q[29:0], 2'b00};
            WR_X:      begin req_we = 1'b1; req_adr = FIR_BASE + 32'h80; req_dat = x_q; end
            RD_Y:      req_adr = FIR_BASE + 32'h80;
            WR_DST:    begin req_we = 1'b1; req_adr = dst_q + {i_q[29:0], 2'b00}; req_dat = y_q; end
            default:   req_adr = FIR_BASE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        i_d     = i_q;
        x_d     = x_q;
        y_d     = y_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        busy_d  = busy_q;
        err_d   = err_q;
        done_d  = 1'b0;
        tmo_d   = '0;

        if (cyc_q) begin
            if (m_ack_i) begin
                cyc_d = 1'b0;
                case (state_q)
                    CFG_LEN:   state_d = CFG_START;
                    CFG_START: state_d = RD_SRC;
                    RD_SRC:    begin x_d = m_dat_i; state_d = WR_X; end
                    WR_X:      state_d = RD_Y;
                    RD_Y:      begin y_d = m_dat_i; state_d = WR_DST; end
                    WR_DST: begin
                        i_d     = i_q + 32'd1;
                        state_d = (i_q + 32'd1 == len_q) ? POLL : RD_SRC;
                    end
                    POLL:      if (m_dat_i[1]) state_d = FIN;
                    default:   state_d = state_q;
                endcase
            end else if (timeout) begin
                cyc_d   = 1'b0;
                err_d   = 1'b1;
                state_d = FIN;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    len_d = len;
                    src_d = {src_base[31:2], 2'b00};
                    dst_d = {dst_base[31:2], 2'b00};
                    i_d   = '0;
                    err_d = 1'b0;
                    if (len == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = CFG_LEN;
                        busy_d  = 1'b1;
                    end
                end
                FIN:  state_d = IDLE;
                // Entering a transfer state with the bus idle always costs one gap cycle here.
                default: begin
                    cyc_d = 1'b1;
                    we_d  = req_we;
                    adr_d = req_adr;
                    dat_d = req_dat;
                end
            endcase
        end

        if (state_d == FIN) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            i_q     <= i_d;
            x_q     <= x_d;
            y_q     <= y_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign m_cyc_o = cyc_q;
    assign m_stb_o = cyc_q;
    assign m_we_o  = we_q;
    assign m_sel_o = 4'hF;
    assign m_adr_o = adr_q;
    assign m_dat_o = dat_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fir_wb_sequencer.sv
// Bench for fir_wb_sequencer: behavioural FIR slave (y=2x) plus memory, and a transaction
// list model checked against the bus on every cycle.
module tb_fir_wb_sequencer;

    localparam logic [31:0] FIRB = 32'h3000_0300;
    localparam int unsigned TMO  = 15;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        start = 1'b0;
    logic [31:0] len = '0, src_base = '0, dst_base = '0;
    logic        busy, done, err;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic        m_ack_i = 1'b0;
    logic [31:0] m_dat_i = '0;

    fir_wb_sequencer #(.FIR_BASE(FIRB), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start(start), .len(len),
        .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done), .err(err),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
    );

    always #5 clk = ~clk;

    int unsigned nvec = 0, nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural slave: memory + FIR ----------------
    logic [31:0] mem [logic [31:0]];
    logic [31:0] fifo [$];
    int unsigned cfg_delay = 0, cfg_polls = 0;
    bit          cfg_noack = 0;
    int unsigned wcnt = 0, polls_seen = 0, pops = 0;
    logic [31:0] fir_len = '0;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge clk) begin
        #1;
        if (m_ack_i) begin
            m_ack_i = 1'b0;
        end else if (m_cyc_o && m_stb_o) begin
            wcnt++;
            if (!(cfg_noack && !m_we_o && m_adr_o == FIRB + 32'h80) && wcnt > cfg_delay) begin
                wcnt = 0;
                m_ack_i = 1'b1;
                if (m_we_o) begin
                    if (m_adr_o == FIRB + 32'h10) fir_len = m_dat_o;
                    else if (m_adr_o == FIRB) begin
                        if (m_dat_o[0]) begin fifo.delete(); polls_seen = 0; pops = 0; end
                    end
                    else if (m_adr_o == FIRB + 32'h80) fifo.push_back(m_dat_o);
                    else mem[m_adr_o] = m_dat_o;
                end else begin
                    if (m_adr_o == FIRB) begin
                        polls_seen++;
                        m_dat_i = (pops >= fir_len && polls_seen > cfg_polls) ? 32'h2 : 32'h0;
                    end else if (m_adr_o == FIRB + 32'h80) begin
                        m_dat_i = (fifo.size() != 0) ? 32'(2 * fifo.pop_front()) : 32'h0;
                        pops++;
                    end else begin
                        m_dat_i = rd_mem(m_adr_o);
                    end
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    // ---------------- expected transaction list ----------------
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int unsigned cyc;
    } xfer_t;
    xfer_t exp_q [$];
    logic [31:0] xv [0:7];

    function automatic void push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input int unsigned cyc);
        xfer_t t;
        t.we = we; t.adr = adr; t.dat = dat; t.cyc = cyc;
        exp_q.push_back(t);
    endfunction

    task automatic build_expected(input int unsigned n, input logic [31:0] src, input logic [31:0] dst,
                                  input int unsigned dly, input int unsigned polls, input bit noack);
        logic [31:0] s, d;
        s = src & ~32'h3;
        d = dst & ~32'h3;
        exp_q.delete();
        if (n == 0) return;
        push(1'b1, FIRB + 32'h10, n, dly + 1);
        push(1'b1, FIRB, 32'h1, dly + 1);
        for (int unsigned i = 0; i < n; i++) begin
            push(1'b0, s + 32'(4 * i), '0, dly + 1);
            push(1'b1, FIRB + 32'h80, xv[i], dly + 1);
            if (noack) begin
                push(1'b0, FIRB + 32'h80, '0, TMO);
                return;
            end
            push(1'b0, FIRB + 32'h80, '0, dly + 1);
            push(1'b1, d + 32'(4 * i), 32'(2 * xv[i]), dly + 1);
        end
        for (int unsigned p = 0; p <= polls; p++) push(1'b0, FIRB, '0, dly + 1);
    endtask

    // ---------------- per-cycle bus monitor / compare ----------------
    bit          in_xfer = 0;
    int unsigned xcyc = 0, xfers = 0, done_cnt = 0;
    xfer_t       cur;
    logic        r_we;
    logic [31:0] r_adr, r_dat;

    always @(negedge clk) begin
        if (wb_rst_i) begin
            in_xfer = 0;
        end else begin
            chk("stb_eq_cyc", 32'(m_stb_o), 32'(m_cyc_o));
            chk("sel", 32'(m_sel_o), 32'hF);
            if (done) done_cnt++;
            if (m_cyc_o && !in_xfer) begin
                in_xfer = 1; xcyc = 1; xfers++;
                r_we = m_we_o; r_adr = m_adr_o; r_dat = m_dat_o;
                chk("busy_in_xfer", 32'(busy), 32'h1);
                if (exp_q.size() == 0) begin
                    nvec++; nmis++;
                    cur.cyc = 0;
                    $display("FAIL unexpected_xfer: got adr %0h we %0b expected no transfer", m_adr_o, m_we_o);
                end else begin
                    cur = exp_q.pop_front();
                    chk("xfer_we", 32'(m_we_o), 32'(cur.we));
                    chk("xfer_adr", m_adr_o, cur.adr);
                    if (cur.we) chk("xfer_dat", m_dat_o, cur.dat);
                end
            end else if (m_cyc_o) begin
                xcyc++;
                chk("hold_we", 32'(m_we_o), 32'(r_we));
                chk("hold_adr", m_adr_o, r_adr);
                chk("hold_dat", m_dat_o, r_dat);
            end else if (in_xfer) begin
                in_xfer = 0;
                chk("xfer_cycles", xcyc, cur.cyc);
                chk("done_at_end", 32'(done), 32'(exp_q.size() == 0));
                chk("busy_at_end", 32'(busy), 32'(exp_q.size() != 0));
            end
        end
    end

    // ---------------- directed cases ----------------
    task automatic run_case(input int unsigned n, input logic [31:0] src, input logic [31:0] dst,
                            input int unsigned dly, input int unsigned polls, input bit noack,
                            input logic exp_err);
        int unsigned d0;
        cfg_delay = dly; cfg_polls = polls; cfg_noack = noack;
        for (int unsigned i = 0; i < n; i++) mem[(src & ~32'h3) + 32'(4 * i)] = xv[i];
        build_expected(n, src, dst, dly, polls, noack);
        d0 = done_cnt;
        start = 1'b1; len = n; src_base = src; dst_base = dst;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(n != 0));
        chk("err_cleared", 32'(err), 32'h0);
        if (n == 0) chk("len0_done_next", 32'(done), 32'h1);
        for (int c = 0; c < 4000 && done_cnt == d0; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("done_pulses", done_cnt - d0, 32'h1);
        chk("err_final", 32'(err), 32'(exp_err));
        chk("busy_final", 32'(busy), 32'h0);
        chk("exp_left", exp_q.size(), 32'h0);
    endtask

    initial begin
        int unsigned x0;
        bit hit;
        for (int i = 0; i < 8; i++) xv[i] = 32'(i + 1);
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(m_cyc_o), 32'h0);
        chk("rst_stb", 32'(m_stb_o), 32'h0);
        chk("rst_we", 32'(m_we_o), 32'h0);
        chk("rst_adr", m_adr_o, 32'h0);
        chk("rst_dat", m_dat_o, 32'h0);
        chk("rst_sel", 32'(m_sel_o), 32'hF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        wb_rst_i = 1'b0;
        @(negedge clk);

        // basic stream, dst low bits must be ignored
        x0 = xfers;
        run_case(3, 32'h3800_0000, 32'h3800_0102, 0, 0, 0, 1'b0);
        chk("A_xfers", xfers - x0, 32'd15);
        chk("A_dst0", rd_mem(32'h3800_0100), 32'd2);
        chk("A_dst1", rd_mem(32'h3800_0104), 32'd4);
        chk("A_dst2", rd_mem(32'h3800_0108), 32'd6);

        x0 = xfers;
        run_case(0, 32'h3800_0000, 32'h3800_0100, 0, 0, 0, 1'b0);
        chk("B_no_xfers", xfers - x0, 32'd0);

        // slow slave
        x0 = xfers;
        run_case(3, 32'h3800_0000, 32'h3800_0200, 5, 0, 0, 1'b0);
        chk("C_xfers", xfers - x0, 32'd15);
        chk("C_dst0", rd_mem(32'h3800_0200), 32'd2);
        chk("C_dst1", rd_mem(32'h3800_0204), 32'd4);
        chk("C_dst2", rd_mem(32'h3800_0208), 32'd6);

        // RD_Y never acked
        x0 = xfers;
        run_case(3, 32'h3800_0000, 32'h3800_0300, 0, 0, 1, 1'b1);
        chk("D_xfers", xfers - x0, 32'd5);
        run_case(0, 32'h3800_0000, 32'h3800_0300, 0, 0, 0, 1'b0);

        // ap_done held low for four polls
        xv[0] = 32'd7; xv[1] = 32'd9;
        x0 = xfers;
        run_case(1, 32'h3800_0040, 32'h3800_0400, 0, 4, 0, 1'b0);
        chk("E_xfers", xfers - x0, 32'd11);
        chk("E_dst0", rd_mem(32'h3800_0400), 32'd14);

        // reset during WR_X
        cfg_delay = 3; cfg_polls = 0; cfg_noack = 0;
        mem[32'h3800_0040] = xv[0]; mem[32'h3800_0044] = xv[1];
        build_expected(2, 32'h3800_0040, 32'h3800_0500, 3, 0, 0);
        start = 1'b1; len = 2; src_base = 32'h3800_0040; dst_base = 32'h3800_0500;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge clk);
            hit = m_cyc_o && m_we_o && (m_adr_o == FIRB + 32'h80);
        end
        chk("F_wrx_reached", 32'(hit), 32'h1);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("F_rst_cyc", 32'(m_cyc_o), 32'h0);
        chk("F_rst_stb", 32'(m_stb_o), 32'h0);
        chk("F_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        #2 wb_rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        x0 = xfers;
        run_case(1, 32'h3800_0040, 32'h3800_0500, 0, 0, 0, 1'b0);
        chk("F_xfers", xfers - x0, 32'd7);
        chk("F_dst0", rd_mem(32'h3800_0500), 32'd14);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
